// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Shares the register-file write port between the main pipeline (A,
//            priority) and a FIFO-buffered multicycle unit (B). The optional
//            starvation guard is enabled with macro RF_WB_ARB_STARVE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [4:0]                   a_index,
  input  logic [31:0]                  a_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [4:0]                   b_index,
  input  logic [31:0]                  b_data,
  output logic                         rf_write_enable,
  output logic [4:0]                   rf_write_index,
  output logic [31:0]                  rf_write_data,
  output logic [$clog2(DEPTH+1)-1:0]   b_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("rf_wb_arbiter: DEPTH must be in 1..8");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("rf_wb_arbiter: MAX_WAIT must be in 1..15");
  end

  logic [4:0]    idx_mem_q  [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, we_d;
  logic [4:0]    widx_q, widx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          fifo_empty, guard_fire, a_write, b_push, b_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);

`ifdef RF_WB_ARB_STARVE_EN
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  logic [3:0] wait_q, wait_d;

  // Guard steals the port from A for one cycle so the head can drain.
  assign guard_fire = !fifo_empty && (wait_q == WAIT_MAX);

  always_comb begin
    wait_d = wait_q;
    if (b_pop || fifo_empty) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign guard_fire = 1'b0;
`endif

  assign a_ready = reset && !guard_fire;
  assign b_ready = reset && (count_q < FULL_CNT);

  // Index-0 writes are accepted but never reach the register file.
  assign a_write = a_valid && a_ready && (a_index != 5'd0);
  assign b_push  = b_valid && b_ready && (b_index != 5'd0);
  assign b_pop   = reset && !fifo_empty && !a_write;

  always_comb begin
    rptr_d  = b_pop  ? ptr_inc(rptr_q) : rptr_q;
    wptr_d  = b_push ? ptr_inc(wptr_q) : wptr_q;
    count_d = count_q;
    if (b_push && !b_pop) begin
      count_d = count_q + 1'b1;
    end else if (!b_push && b_pop) begin
      count_d = count_q - 1'b1;
    end

    we_d    = 1'b0;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    if (a_write) begin
      we_d    = 1'b1;
      widx_d  = a_index;
      wdata_d = a_data;
    end else if (b_pop) begin
      we_d    = 1'b1;
      widx_d  = idx_mem_q[rptr_q];
      wdata_d = data_mem_q[rptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (b_push) begin
      idx_mem_q[wptr_q]  <= b_index;
      data_mem_q[wptr_q] <= b_data;
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_index  = widx_q;
  assign rf_write_data   = wdata_q;
  assign b_count         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// Testbench for rf_wb_arbiter (DEPTH=2, MAX_WAIT=4); table-driven vectors plus
// hand-written starvation and mid-operation reset sequences.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid, a_ready;
  logic [4:0]  a_index;
  logic [31:0] a_data;
  logic        b_valid, b_ready;
  logic [4:0]  b_index;
  logic [31:0] b_data;
  logic        rf_write_enable;
  logic [4:0]  rf_write_index;
  logic [31:0] rf_write_data;
  logic [1:0]  b_count;

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_index(a_index), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_index(b_index), .b_data(b_data),
    .rf_write_enable(rf_write_enable), .rf_write_index(rf_write_index),
    .rf_write_data(rf_write_data), .b_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ai;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  bi;
    logic [31:0] bd;
    logic        ear;
    logic        ebr;
    logic        ewe;
    logic [4:0]  eidx;
    logic [31:0] edat;
    logic [1:0]  ecnt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic bv, input logic [4:0] bi, input logic [31:0] bd);
    a_valid = av; a_index = ai; a_data = ad;
    b_valid = bv; b_index = bi; b_data = bd;
  endtask

  // Called right after drive(): readies in-cycle, then registered outputs after the edge.
  task automatic step_chk(input string tag, input logic ear, input logic ebr,
                          input logic ewe, input logic [4:0] eidx,
                          input logic [31:0] edat, input logic [1:0] ecnt);
    #1;
    chk({tag, ".a_ready"}, {31'd0, a_ready}, {31'd0, ear});
    chk({tag, ".b_ready"}, {31'd0, b_ready}, {31'd0, ebr});
    @(posedge clk);
    #1;
    chk({tag, ".we"},    {31'd0, rf_write_enable}, {31'd0, ewe});
    chk({tag, ".index"}, {27'd0, rf_write_index},  {27'd0, eidx});
    chk({tag, ".data"},  rf_write_data,            edat);
    chk({tag, ".count"}, {30'd0, b_count},         {30'd0, ecnt});
  endtask

  initial begin : main
    logic [31:0] adata;
    logic [31:0] last_a;
    logic        ear;

    //          av    ai     ad            bv    bi      bd      ear   ebr   ewe   eidx   edat           ecnt
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 2'd0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 2'd0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h12, 1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 2'd1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b1, 5'd7,  32'h12,       2'd0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b0, 5'd7,  32'h12,       2'd0};
    vecs[5]  = '{1'b1, 5'd1,  32'h100,      1'b1, 5'd10, 32'hA0, 1'b1, 1'b1, 1'b1, 5'd1,  32'h100,      2'd1};
    vecs[6]  = '{1'b1, 5'd1,  32'h101,      1'b1, 5'd11, 32'hA1, 1'b1, 1'b1, 1'b1, 5'd1,  32'h101,      2'd2};
    vecs[7]  = '{1'b1, 5'd1,  32'h102,      1'b1, 5'd12, 32'hA2, 1'b1, 1'b0, 1'b1, 5'd1,  32'h102,      2'd2};
    vecs[8]  = '{1'b1, 5'd0,  32'h999,      1'b1, 5'd12, 32'hA2, 1'b1, 1'b0, 1'b1, 5'd10, 32'hA0,       2'd1};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hA2, 1'b1, 1'b1, 1'b1, 5'd11, 32'hA1,       2'd1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b1, 5'd12, 32'hA2,       2'd0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55, 1'b1, 1'b1, 1'b0, 5'd12, 32'hA2,       2'd0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b0, 5'd12, 32'hA2,       2'd0};

    // Reset held 3 cycles with both requesters active.
    reset = 1'b0;
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h33);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst.a_ready", {31'd0, a_ready}, 32'd0);
      chk("rst.b_ready", {31'd0, b_ready}, 32'd0);
      chk("rst.we",      {31'd0, rf_write_enable}, 32'd0);
      chk("rst.index",   {27'd0, rf_write_index}, 32'd0);
      chk("rst.data",    rf_write_data, 32'd0);
      chk("rst.count",   {30'd0, b_count}, 32'd0);
    end
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].av, vecs[i].ai, vecs[i].ad, vecs[i].bv, vecs[i].bi, vecs[i].bd);
      step_chk($sformatf("vec%0d", i), vecs[i].ear, vecs[i].ebr, vecs[i].ewe,
               vecs[i].eidx, vecs[i].edat, vecs[i].ecnt);
    end

    // One B entry queued behind continuous A traffic.
    drive(1'b1, 5'd2, 32'h200, 1'b1, 5'd20, 32'hB0);
    step_chk("starve.push", 1'b1, 1'b1, 1'b1, 5'd2, 32'h200, 2'd1);
    adata  = 32'h300;
    last_a = 32'h200;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 5'd3, adata, 1'b0, 5'd0, 32'h0);
`ifdef RF_WB_ARB_STARVE_EN
      ear = (k != 5);
      if (k == 5) begin
        step_chk($sformatf("guard%0d", k), 1'b0, 1'b1, 1'b1, 5'd20, 32'hB0, 2'd0);
      end else begin
        step_chk($sformatf("guard%0d", k), 1'b1, 1'b1, 1'b1, 5'd3, adata,
                 (k < 5) ? 2'd1 : 2'd0);
      end
`else
      ear = 1'b1;
      step_chk($sformatf("noguard%0d", k), 1'b1, 1'b1, 1'b1, 5'd3, adata, 2'd1);
`endif
      if (ear) begin
        last_a = adata;
        adata  = adata + 32'd1;
      end
    end

    // A goes idle: any still-pending B entry drains now.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`ifdef RF_WB_ARB_STARVE_EN
    step_chk("starve.idle", 1'b1, 1'b1, 1'b0, 5'd3, last_a, 2'd0);
`else
    step_chk("starve.drain", 1'b1, 1'b1, 1'b1, 5'd20, 32'hB0, 2'd0);
`endif

    // Fill the FIFO, then reset mid-operation.
    drive(1'b1, 5'd4, 32'h400, 1'b1, 5'd21, 32'hC1);
    step_chk("mid.fill0", 1'b1, 1'b1, 1'b1, 5'd4, 32'h400, 2'd1);
    drive(1'b1, 5'd4, 32'h401, 1'b1, 5'd22, 32'hC2);
    step_chk("mid.fill1", 1'b1, 1'b1, 1'b1, 5'd4, 32'h401, 2'd2);

    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd23, 32'hC3);
    step_chk("mid.rst0", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 2'd0);
    step_chk("mid.rst1", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 2'd0);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step_chk($sformatf("mid.idle%0d", i), 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 2'd0);
    end

    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    step_chk("post.push", 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 2'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step_chk("post.write", 1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

- Shares the register file's single write port between two writeback sources:
  - the main pipeline (requester A);
  - a multicycle unit such as mul/div or a load unit (requester B).
- A has priority. B results are held in a small FIFO and drained into idle write-port cycles.
- An optional starvation guard forces a B drain after a bounded wait.
- Outputs are registered and drive the register file's write_enable, write_index and write_data directly.

## Interface

Parameters:
- DEPTH, default 2: B FIFO entries, legal range 1..8.
- MAX_WAIT, default 4: cycles a non-empty FIFO head may wait before the guard fires, legal range 1..15.

Ports:
- clk, input, 1: single clock, rising-edge.
- reset, input, 1: synchronous, active-low reset.
- a_valid, input, 1: A has a writeback this cycle.
- a_ready, output, 1: A writeback accepted this cycle.
- a_index, input, 5: A destination register.
- a_data, input, 32: A write data.
- b_valid, input, 1: B offers a result.
- b_ready, output, 1: FIFO can accept a B result.
- b_index, input, 5: B destination register.
- b_data, input, 32: B write data.
- rf_write_enable, output, 1: to register file write_enable.
- rf_write_index, output, 5: to register file write_index.
- rf_write_data, output, 32: to register file write_data.
- b_count, output, $clog2(DEPTH+1): current FIFO occupancy.

## Operation

- A transfer: a_valid && a_ready.
- B push: b_valid && b_ready.
- b_ready = (b_count < DEPTH). There is no same-cycle bypass of a full FIFO.
- Index 0 handling:
  - A transfer with a_index == 0: accepted, produces no write, and leaves the port free for B this cycle.
  - B push with b_index == 0: accepted, then discarded. It does not occupy an entry and b_count is unchanged.
- Grant, evaluated each cycle:
  - A transfer with nonzero a_index: the output register loads A.
  - Otherwise, if the FIFO is non-empty: pop the head and load it.
  - Otherwise: rf_write_enable loads 0.
- Push and pop in the same cycle: both take effect and b_count is unchanged.
- FIFO is strictly in-order. Read and write pointers wrap modulo DEPTH.
- rf_write_index and rf_write_data hold their last value when rf_write_enable is 0.
- No index-ordering checks exist between A and B. The producer must guarantee that no WAW conflict exists for the same index.
- While reset is low:
  - a_ready = 0 and b_ready = 0.
  - FIFO pointers and b_count go to 0. Any entries in flight are discarded and never written.
  - rf_write_enable = 0, rf_write_index = 0, rf_write_data = 0.
  - Wait counter = 0.

## Timing

- All state and outputs update on the rising edge of clk.
- The register file samples on the following falling edge.
- A latency: a transfer in cycle N gives rf_write_enable high during cycle N+1.
- B latency: a push in cycle N gives a pop at the earliest in cycle N+1, so the write is visible at N+2.
- b_ready is combinational from b_count. a_ready is combinational from the wait counter and b_count.
- Wait counter:
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on a pop or when the FIFO is empty.
  - Saturates at MAX_WAIT.
- When the counter equals MAX_WAIT and the FIFO is non-empty:
  - a_ready = 0 for that cycle;
  - the head pops;
  - the counter returns to 0.
- A must hold a_valid, a_index and a_data while a_ready is low.
- Maximum back-to-back A throughput with the guard on: MAX_WAIT accepted per MAX_WAIT+1 cycles while B is pending.
- Reset released in cycle N: a_ready and b_ready are valid in cycle N+1.

## Configuration

- Macro: RF_WB_ARB_STARVE_EN.
- Defined: wait counter and guard are present as described in Timing.
- Undefined:
  - No wait counter.
  - a_ready = 1 whenever reset is high.
  - B drains only in cycles with no A write to a nonzero index, so B can starve indefinitely.
  - All other behaviour is identical.

## Test plan

- **Reset:** hold reset low 3 cycles with b_valid = 1 → b_ready = 0, a_ready = 0, rf_write_enable = 0, b_count = 0 throughout.
- **Basic A and B paths:**
  - A writes x5 = 0xDEADBEEF → rf_write_enable = 1, index 5, data 0xDEADBEEF one cycle later.
  - Idle-port B writes x7 = 0x12 → write appears 2 cycles after the push.
- **Fill and discard:**
  - A continuously writes x1 while B pushes 3 results with DEPTH = 2 → b_ready drops after the 2nd push, b_count = 2, no loss.
  - A sends a_index = 0 → head drains that cycle.
  - B push with b_index = 0 → b_count unchanged, no write.
- **Starvation guard on (MAX_WAIT = 4):** a_valid = 1 every cycle to nonzero indices, one B entry queued → a_ready low exactly on the 5th cycle, B entry written next cycle, A resumes.
- **Guard off:** same stimulus → a_ready stays 1, B entry never written, b_count stays 1.
- **Mid-operation reset:** assert reset with b_count = 2 → after release b_count = 0, neither discarded entry is ever written, next B push writes normally.
